// File: rtl/tmds_dec.sv
// Receive-side TMDS channel decoder: finds 10-bit word alignment from control-token
// runs, then recovers pixel bytes, DE and control values with a fixed 2-cycle latency.
module tmds_dec #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] din_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int              RUN_W       = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(LOCK_COUNT);
    localparam logic [15:0]     SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0]     LOSS_LAST   = 16'(LOSS_TIMEOUT - 1);
    localparam logic [3:0]      LAST_OFFSET = 4'd9;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       w0_q, w1_q;
    logic [19:0]      ext;
    logic [9:0]       win;
    logic [RUN_W-1:0] run_q, run_d;
    logic [15:0]      timer_q, timer_d;
    logic [3:0]       offset_q, offset_d;
    logic             is_tok;
    logic [1:0]       tok_val;
    logic [7:0]       qp;
    logic [7:0]       dec;

    // The window straddles the two most recent words; w0 holds the older bits.
    always_comb begin
        ext = {w1_q, w0_q};
        win = 10'(ext >> offset_q);
    end

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (win)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    always_comb begin
        qp     = win[9] ? ~win[7:0] : win[7:0];
        dec    = 8'h00;
        dec[0] = qp[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = win[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        run_d    = run_q;
        timer_d  = timer_q;
        offset_d = offset_q;
        case (state_q)
            SEARCH: begin
                if (is_tok && run_q >= RUN_MAX - 1'b1) begin
                    // Lock takes priority over a coincident timeout; offset stays put.
                    state_d = LOCKED;
                    run_d   = RUN_MAX;
                    timer_d = 16'd0;
                end else if (timer_q == SEARCH_LAST) begin
                    offset_d = (offset_q == LAST_OFFSET) ? 4'd0 : offset_q + 4'd1;
                    run_d    = '0;
                    timer_d  = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                    run_d   = is_tok ? run_q + 1'b1 : '0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    timer_d = 16'd0;
                end else if (timer_q == LOSS_LAST) begin
                    state_d = SEARCH;
                    run_d   = '0;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Outputs follow the next state so the lock-completing token and the loss edge line up.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q  <= SEARCH;
            w0_q     <= 10'd0;
            w1_q     <= 10'd0;
            run_q    <= '0;
            timer_q  <= 16'd0;
            offset_q <= 4'd0;
            locked_o <= 1'b0;
            de_o     <= 1'b0;
            ctrl_o   <= 2'b00;
            data_o   <= 8'h00;
        end else begin
            state_q  <= state_d;
            w1_q     <= din_i;
            w0_q     <= w1_q;
            run_q    <= run_d;
            timer_q  <= timer_d;
            offset_q <= offset_d;
            locked_o <= (state_d == LOCKED);
            if (state_d == LOCKED) begin
                de_o   <= ~is_tok;
                ctrl_o <= is_tok ? tok_val : 2'b00;
                data_o <= is_tok ? 8'h00 : dec;
            end else begin
                de_o   <= 1'b0;
                ctrl_o <= 2'b00;
                data_o <= 8'h00;
            end
        end
    end

    assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_dec.sv
// Randomized bench for tmds_dec: a bit-stream reference model predicts every output each
// cycle, plus directed checks for lock timing, offset search, loss of lock and reset.
module tb_tmds_dec;

    localparam int LOCK_COUNT     = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int LOSS_TIMEOUT   = 128;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [9:0] din_i;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    tmds_dec #(
        .LOCK_COUNT    (LOCK_COUNT),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (din_i),
        .data_o  (data_o),
        .de_o    (de_o),
        .ctrl_o  (ctrl_o),
        .locked_o(locked_o),
        .offset_o(offset_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference model state: last two words, search/lock bookkeeping as plain integers.
    logic [9:0] m_w0, m_w1;
    int         m_run, m_timer, m_off;
    bit         m_locked;
    logic [7:0] e_data;
    logic       e_de;
    logic [1:0] e_ctrl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == tok_tbl[k]) return k;
        return -1;
    endfunction

    // Adjacent-bit differences are unaffected by the inversion flag, so only q[8] matters above bit 0.
    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] b;
        b[0] = q[0] ^ q[9];
        for (int i = 1; i < 8; i++) b[i] = q[i] ^ q[i-1] ^ ~q[8];
        return b;
    endfunction

    function automatic logic [9:0] encode(input logic [7:0] d, input bit xor_mode, input bit inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xor_mode ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return {inv, xor_mode, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rand_data_word();
        logic [9:0] w;
        do begin
            w = encode(8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end while (tok_index(w) >= 0);
        return w;
    endfunction

    // Window taken from the serial bit stream: older word's bits first, then the newer word's.
    function automatic logic [9:0] model_window();
        logic [9:0] w;
        for (int j = 0; j < 10; j++) begin
            int p;
            p    = m_off + j;
            w[j] = (p < 10) ? m_w0[p] : m_w1[p-10];
        end
        return w;
    endfunction

    task automatic model_edge(input logic [9:0] din, input bit rst);
        logic [9:0] win;
        int         t;
        bit         nxt;
        if (rst) begin
            m_w0 = '0; m_w1 = '0; m_run = 0; m_timer = 0; m_off = 0; m_locked = 0;
            e_data = '0; e_de = 0; e_ctrl = '0;
            return;
        end
        win = model_window();
        t   = tok_index(win);
        nxt = m_locked;
        if (!m_locked) begin
            if (t >= 0 && m_run + 1 >= LOCK_COUNT) begin
                nxt = 1; m_run = LOCK_COUNT; m_timer = 0;
            end else if (m_timer == SEARCH_TIMEOUT - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_timer = 0;
            end else begin
                m_timer++;
                m_run = (t >= 0) ? m_run + 1 : 0;
            end
        end else begin
            if (t >= 0) m_timer = 0;
            else if (m_timer == LOSS_TIMEOUT - 1) begin
                nxt = 0; m_run = 0; m_timer = 0;
            end else m_timer++;
        end
        m_locked = nxt;
        if (m_locked && t >= 0) begin
            e_de = 0; e_ctrl = 2'(t); e_data = '0;
        end else if (m_locked) begin
            e_de = 1; e_ctrl = '0; e_data = ref_decode(win);
        end else begin
            e_de = 0; e_ctrl = '0; e_data = '0;
        end
        m_w0 = m_w1;
        m_w1 = din;
    endtask

    task automatic step(input logic [9:0] din, input bit rst = 1'b0);
        @(negedge clk_i);
        din_i = din;
        rst_i = rst;
        @(posedge clk_i);
        model_edge(din, rst);
        #1;
        check("out", {locked_o, offset_o, de_o, ctrl_o, data_o},
              {m_locked, 4'(m_off), e_de, e_ctrl, e_data});
    endtask

    function automatic logic [9:0] rot_word();
        logic [9:0] w;
        for (int b = 0; b < 10; b++) w[b] = tok_tbl[2][(b + 7) % 10];
        return w;
    endfunction

    logic [9:0]  sweep_w [20];
    logic [10:0] sweep_e [20];
    logic [7:0]  bytes [4] = '{8'h00, 8'hFF, 8'hA5, 8'h10};

    initial begin
        rst_i = 1'b1;
        din_i = '0;
        step(10'd0, 1'b1);
        step(10'd0, 1'b1);
        check("reset_out", {locked_o, offset_o, de_o, ctrl_o, data_o}, 16'h0000);

        // Aligned stream: lock two cycles after the 8th token, then 2-cycle data latency.
        for (int i = 1; i <= 16; i++) begin
            step(tok_tbl[0]);
            if (i == 9)  check("lock_early", locked_o, 1'b0);
            if (i == 10) check("lock_rise", {locked_o, de_o, offset_o}, {1'b1, 1'b0, 4'd0});
        end
        for (int i = 1; i <= 4; i++) begin
            step(10'b0100000000);
            if (i == 2) check("lat_token", de_o, 1'b0);
            if (i == 3) check("lat_data", {de_o, data_o}, {1'b1, 8'h00});
        end

        // Decode sweep: each byte in all four polarity combinations, then the four tokens.
        for (int b = 0; b < 4; b++) begin
            for (int m = 0; m < 4; m++) begin
                sweep_w[b*4+m] = encode(bytes[b], m[0], m[1]);
                sweep_e[b*4+m] = (tok_index(sweep_w[b*4+m]) >= 0)
                               ? {1'b0, 2'(tok_index(sweep_w[b*4+m])), 8'h00}
                               : {1'b1, 2'b00, bytes[b]};
            end
        end
        for (int k = 0; k < 4; k++) begin
            sweep_w[16+k] = tok_tbl[k];
            sweep_e[16+k] = {1'b0, 2'(k), 8'h00};
        end
        for (int i = 0; i < 22; i++) begin
            step(i < 20 ? sweep_w[i] : tok_tbl[0]);
            if (i >= 2) check($sformatf("sweep%0d", i - 2), {de_o, ctrl_o, data_o}, sweep_e[i-2]);
        end

        // Random traffic while locked: tokens, encoded pixels and raw words.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(3))
                0:       step(tok_tbl[$urandom_range(3)]);
                1, 2:    step(rand_data_word());
                default: step(10'($urandom));
            endcase
        end

        // Loss of lock after LOSS_TIMEOUT token-free windows, then relock.
        for (int i = 0; i < 10; i++) step(tok_tbl[$urandom_range(3)]);
        check("pre_loss", locked_o, 1'b1);
        for (int k = 1; k <= 132; k++) begin
            step(rand_data_word());
            if (k == 129) check("loss_hold", locked_o, 1'b1);
            if (k == 130) check("loss_fall", {locked_o, offset_o, de_o}, {1'b0, 4'd0, 1'b0});
            if (k == 132) check("idle_after_loss", {de_o, data_o}, 9'h000);
        end
        for (int k = 1; k <= 10; k++) begin
            step(tok_tbl[$urandom_range(3)]);
            if (k == 9)  check("relock_early", locked_o, 1'b0);
            if (k == 10) check("relock", locked_o, 1'b1);
        end

        // Offset walk through all ten positions and wrap from 9 back to 0.
        step(10'd0, 1'b1);
        for (int k = 1; k <= 640; k++) begin
            step(rand_data_word());
            if (k == 64)  check("walk_off1", offset_o, 4'd1);
            if (k == 576) check("walk_off9", offset_o, 4'd9);
            if (k == 640) check("walk_wrap", {locked_o, offset_o}, {1'b0, 4'd0});
        end

        // Lock completes on the same edge the search timer expires.
        step(10'd0, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            step((k >= 55 && k <= 62) ? tok_tbl[$urandom_range(3)] : rand_data_word());
            if (k == 63) check("tie_before", locked_o, 1'b0);
            if (k == 64) check("tie_lock", {locked_o, offset_o}, {1'b1, 4'd0});
        end

        // Stream rotated by three bits: lock found at offset 3 after three timeouts.
        step(10'd0, 1'b1);
        for (int k = 1; k <= 400; k++) begin
            step(rot_word());
            if (k == 64)  check("rot_off1", offset_o, 4'd1);
            if (k == 128) check("rot_off2", offset_o, 4'd2);
            if (k == 192) check("rot_off3", offset_o, 4'd3);
            if (locked_o) break;
        end
        check("rot_lock", {locked_o, offset_o, de_o, ctrl_o}, {1'b1, 4'd3, 1'b0, 2'b10});
        for (int k = 0; k < 4; k++) step(rot_word());
        check("rot_ctrl", {locked_o, de_o, ctrl_o}, {1'b1, 1'b0, 2'b10});

        // Reset while locked drops everything on the very next edge.
        step(rot_word(), 1'b1);
        check("rst_locked", {locked_o, offset_o, de_o, ctrl_o, data_o}, 16'h0000);
        step(rot_word());

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tmds_dec.md
# tmds_dec

Receive-side TMDS channel decoder: the inverse of the per-channel TMDS encoder on the video output path. It takes raw, arbitrarily bit-aligned 10-bit words from a deserializer, finds word alignment from control-token runs during blanking, and recovers 8-bit pixel data, DE and the 2-bit control value. One instance per TMDS data channel; it sits between the deserializer and the capture/sync-extraction logic in the pixel-clock domain.

## Interface
- LOCK_COUNT, 8: consecutive control tokens at one offset required to declare lock
- SEARCH_TIMEOUT, 4096: cycles spent at one offset before advancing to the next
- LOSS_TIMEOUT, 8192: cycles in LOCKED with no control token before dropping lock
- clk_i  in  1  pixel clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- din_i  in  10  raw deserialized word; bit 0 is the earliest received bit
- data_o  out  8  decoded pixel byte, valid when de_o=1
- de_o  out  1  data enable (window is not a control token)
- ctrl_o  out  2  decoded control value {c1,c0}, valid when de_o=0
- locked_o  out  1  alignment locked
- offset_o  out  4  current bit offset, 0..9

## Operation
- Window: registers w1 <= din_i, w0 <= w1; ext = {w1, w0} (20 bits, w0 older); window = ext[offset+9 : offset].
- Control tokens (window value -> ctrl): 10'b1101010100 -> 00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11. is_tok = window matches any.
- Data decode (window q): q' = q[9] ? ~q[7:0] : q[7:0]; d[0] = q'[0]; d[i] = q[8] ? q'[i]^q'[i-1] : ~(q'[i]^q'[i-1]), i=1..7.
- FSM states SEARCH, LOCKED. Counters: run (tokens in a row, saturates at LOCK_COUNT), timer (16 bit), offset (4 bit).
- SEARCH: run increments on is_tok, clears on non-token. timer increments every cycle. run reaching LOCK_COUNT -> LOCKED, timer cleared. Else timer == SEARCH_TIMEOUT-1 -> offset = (offset==9) ? 0 : offset+1, run and timer cleared.
- Lock and timeout in the same cycle: lock wins, offset unchanged.
- LOCKED: offset frozen. timer clears on is_tok, else increments; timer == LOSS_TIMEOUT-1 -> SEARCH, run and timer cleared, offset kept (search resumes at the same offset).
- Outputs in LOCKED: is_tok -> de_o=0, ctrl_o=token value, data_o=0; else de_o=1, ctrl_o=00, data_o=d.
- Outputs in SEARCH: de_o=0, ctrl_o=00, data_o=0, regardless of window.
- Tokens are counted irrespective of which of the four values they are; mixed tokens form one run.

## Timing
- Reset: state SEARCH, offset_o=0, locked_o=0, de_o=0, ctrl_o=00, data_o=00, run=0, timer=0, w0=w1=0. Reset mid-operation returns to this state on the next edge, lock discarded.
- Latency: din_i at edge t -> enters w1 at t; is in window (combined with w0) from t+1; data_o/de_o/ctrl_o registered at t+2. Fixed 2-cycle latency once locked.
- locked_o asserts on the same edge where state becomes LOCKED; outputs from the window that completed the run reflect the new state (first locked output is the final lock token, de_o=0).
- Offset change takes effect on the window the cycle after the timeout edge; run counting restarts from 0 there.
- locked_o deasserts on the edge the loss timeout fires; outputs forced idle from that edge.
- No backpressure; one output per clock.

## Test plan
- Aligned stream: 16 x token 10'b1101010100 then data words 10'b0100000000 (decodes to 8'h00? compute: q9=0,q8=1,q'=00 -> 8'h00) -> locked_o=1 after 8th token + 2 cycles, offset_o=0, then de_o=1, data_o=8'h00, latency exactly 2.
- Stream rotated by 3 bits (serial bitstream of repeated token 10'b0101010100 sliced at bit 3): with SEARCH_TIMEOUT=64 -> offset steps 0,1,2,3 every 64 cycles, lock at offset_o=3, ctrl_o=10.
- Data decode sweep at lock: encoded words for bytes 8'h00, 8'hFF, 8'hA5, 8'h10 (both q[9] and q[8] polarities) -> data_o matches, de_o=1; each of the four tokens -> ctrl_o 00/01/10/11, de_o=0.
- Loss of lock: LOSS_TIMEOUT=128, locked, then 128 data words with no token -> locked_o falls on the 128th cycle, offset_o retained, de_o=0 thereafter; tokens return -> relock after 8.
- Wrap and tie: offset at 9 times out -> offset_o=0; lock count reached on timeout cycle -> LOCKED, offset unchanged.
- rst_i pulsed while LOCKED -> next edge locked_o=0, offset_o=0, de_o=0, data_o=0.
